// File: rtl/song_sequencer_if.sv
// -----------------------------------------------------------------------------
// song_sequencer_if
// Bundles the board-side controls of the song sequencer and the results it
// hands to the tone divider and the LED / 7-segment display logic.
//
//   ODETOJOY_AUTO, DOREMI_AUTO,
//   ODETOJOY, DOREMI   : asynchronous song-mode request levels
//   sw[7:0]            : asynchronous piano switches, sw[7] = C .. sw[0] = C'
//   note_code[3:0]     : 0 = rest, 1..8 = C..C'
//   note_valid         : tone enable
//   mode[2:0]          : 0 FREE, 1 AUTO_ODE, 2 AUTO_DRM, 3 GUIDE_ODE, 4 GUIDE_DRM
//   expect_led[7:0]    : one-hot switch the player should press next (guided)
//   step[4:0]          : current song ROM index
//   hits, misses[7:0]  : guided-mode score counters
//   song_done          : one-cycle pulse when a song completes
//
// master : the sequencer (consumes controls, produces results)
// slave  : the board side (drives controls, consumes results)
// -----------------------------------------------------------------------------
interface song_sequencer_if;
    logic       ODETOJOY_AUTO;
    logic       DOREMI_AUTO;
    logic       ODETOJOY;
    logic       DOREMI;
    logic [7:0] sw;
    logic [3:0] note_code;
    logic       note_valid;
    logic [2:0] mode;
    logic [7:0] expect_led;
    logic [4:0] step;
    logic [7:0] hits;
    logic [7:0] misses;
    logic       song_done;

    modport master (
        input  ODETOJOY_AUTO, DOREMI_AUTO, ODETOJOY, DOREMI, sw,
        output note_code, note_valid, mode, expect_led, step, hits, misses, song_done
    );

    modport slave (
        output ODETOJOY_AUTO, DOREMI_AUTO, ODETOJOY, DOREMI, sw,
        input  note_code, note_valid, mode, expect_led, step, hits, misses, song_done
    );
endinterface

// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
// Mode controller and note scheduler in front of the piano tone generator.
// Debounces the four song-mode requests, arbitrates between them and selects
// the note source: switches (FREE), beat-timed song ROM (AUTO) or one ROM step
// per correct key press (GUIDE). All outputs are registered.
//
// Parameters:
//   BEAT_DIV : clock cycles per auto-play beat (>= 4)
//   GAP      : silent cycles at the end of each beat (< BEAT_DIV)
//   DEBOUNCE : consecutive samples needed to accept a new request level
//
// Ports:
//   CLK     : system clock, rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : song_sequencer_if.master (requests, switches and all results)
// -----------------------------------------------------------------------------
module song_sequencer #(
    parameter int BEAT_DIV = 25000000,
    parameter int GAP      = 2500000,
    parameter int DEBOUNCE = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    song_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        FREE      = 3'd0,
        AUTO_ODE  = 3'd1,
        AUTO_DRM  = 3'd2,
        GUIDE_ODE = 3'd3,
        GUIDE_DRM = 3'd4
    } mode_t;

    localparam int BC_W = $clog2(BEAT_DIV);
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BEAT_DIV - 1);
    localparam logic [BC_W-1:0] BC_ON   = BC_W'(BEAT_DIV - GAP);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    // Request bit positions, ordered so that a higher index has higher priority.
    localparam int REQ_ODE_AUTO = 3;
    localparam int REQ_DRM_AUTO = 2;
    localparam int REQ_ODE      = 1;
    localparam int REQ_DRM      = 0;

    logic [3:0]           req_meta, req_sync;
    logic [7:0]           sw_meta, sw_sync, sw_prev;
    logic                 press_q;
    logic [3:0]           press_code_q;

    logic [3:0]           deb_q, deb_next, rise, fall;
    logic [3:0][DB_W-1:0] cnt_q, cnt_next;

    mode_t                mode_q, mode_next;
    logic [4:0]           step_q, step_next;
    logic [BC_W-1:0]      bc_q, bc_next;
    logic [7:0]           hits_q, hits_next;
    logic [7:0]           misses_q, misses_next;

    logic [3:0]           note_q, note_next;
    logic                 valid_q, valid_next;
    logic [7:0]           expect_q, expect_next;
    logic                 done_q, done_next;

    logic                 entering;
    logic                 at_last;
    logic [3:0]           cur_note;
    logic [1:0]           own_idx;

    function automatic logic [3:0] ode_note(input logic [4:0] idx);
        case (idx)
            5'd0:  ode_note = 4'd3;  5'd1:  ode_note = 4'd3;
            5'd2:  ode_note = 4'd4;  5'd3:  ode_note = 4'd5;
            5'd4:  ode_note = 4'd5;  5'd5:  ode_note = 4'd4;
            5'd6:  ode_note = 4'd3;  5'd7:  ode_note = 4'd2;
            5'd8:  ode_note = 4'd1;  5'd9:  ode_note = 4'd1;
            5'd10: ode_note = 4'd2;  5'd11: ode_note = 4'd3;
            5'd12: ode_note = 4'd3;  5'd13: ode_note = 4'd2;
            5'd14: ode_note = 4'd2;  5'd15: ode_note = 4'd3;
            5'd16: ode_note = 4'd3;  5'd17: ode_note = 4'd4;
            5'd18: ode_note = 4'd5;  5'd19: ode_note = 4'd5;
            5'd20: ode_note = 4'd4;  5'd21: ode_note = 4'd3;
            5'd22: ode_note = 4'd2;  5'd23: ode_note = 4'd1;
            5'd24: ode_note = 4'd1;  5'd25: ode_note = 4'd2;
            5'd26: ode_note = 4'd3;  5'd27: ode_note = 4'd2;
            5'd28: ode_note = 4'd1;  5'd29: ode_note = 4'd1;
            default: ode_note = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] drm_note(input logic [4:0] idx);
        case (idx)
            5'd0:  drm_note = 4'd1;  5'd1:  drm_note = 4'd2;
            5'd2:  drm_note = 4'd3;  5'd3:  drm_note = 4'd4;
            5'd4:  drm_note = 4'd5;  5'd5:  drm_note = 4'd6;
            5'd6:  drm_note = 4'd7;  5'd7:  drm_note = 4'd8;
            5'd8:  drm_note = 4'd8;  5'd9:  drm_note = 4'd7;
            5'd10: drm_note = 4'd6;  5'd11: drm_note = 4'd5;
            5'd12: drm_note = 4'd4;  5'd13: drm_note = 4'd3;
            5'd14: drm_note = 4'd2;  5'd15: drm_note = 4'd1;
            default: drm_note = 4'd0;
        endcase
    endfunction

    function automatic logic is_ode(input mode_t m);
        is_ode = (m == AUTO_ODE) || (m == GUIDE_ODE);
    endfunction

    function automatic logic is_auto(input mode_t m);
        is_auto = (m == AUTO_ODE) || (m == AUTO_DRM);
    endfunction

    function automatic logic is_guide(input mode_t m);
        is_guide = (m == GUIDE_ODE) || (m == GUIDE_DRM);
    endfunction

    function automatic logic [3:0] song_note(input mode_t m, input logic [4:0] idx);
        song_note = is_ode(m) ? ode_note(idx) : drm_note(idx);
    endfunction

    function automatic logic [4:0] song_last(input mode_t m);
        song_last = is_ode(m) ? 5'd29 : 5'd15;
    endfunction

    // Later (higher) switches overwrite earlier ones, so sw[7] wins.
    function automatic logic [3:0] decode_sw(input logic [7:0] s);
        decode_sw = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) decode_sw = 4'(8 - i);
        end
    endfunction

    function automatic logic [7:0] note_onehot(input logic [3:0] note);
        logic [3:0] sh;
        sh          = 4'd8 - note;
        note_onehot = 8'd1 << sh;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A debounced level flips on the sample that completes DEBOUNCE
    // consecutive disagreeing samples; rise/fall are taken from that same
    // next value so the mode reacts on the edge the level is accepted.
    always_comb begin
        deb_next = deb_q;
        cnt_next = '0;
        for (int i = 0; i < 4; i++) begin
            if (req_sync[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_next[i] = req_sync[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = deb_next & ~deb_q;
    assign fall = deb_q & ~deb_next;

    always_comb begin
        case (mode_q)
            AUTO_ODE:  own_idx = 2'(REQ_ODE_AUTO);
            AUTO_DRM:  own_idx = 2'(REQ_DRM_AUTO);
            GUIDE_ODE: own_idx = 2'(REQ_ODE);
            default:   own_idx = 2'(REQ_DRM);
        endcase
    end

    // Mode FSM next-state and output-register inputs.
    always_comb begin
        mode_next   = mode_q;
        step_next   = step_q;
        bc_next     = bc_q;
        hits_next   = hits_q;
        misses_next = misses_q;
        done_next   = 1'b0;
        entering    = 1'b0;
        cur_note    = song_note(mode_q, step_q);
        at_last     = (step_q == song_last(mode_q));

        case (mode_q)
            FREE: begin
                if (rise[REQ_ODE_AUTO])      mode_next = AUTO_ODE;
                else if (rise[REQ_DRM_AUTO]) mode_next = AUTO_DRM;
                else if (rise[REQ_ODE])      mode_next = GUIDE_ODE;
                else if (rise[REQ_DRM])      mode_next = GUIDE_DRM;
                if (rise != 4'd0) begin
                    entering    = 1'b1;
                    step_next   = 5'd0;
                    bc_next     = '0;
                    hits_next   = 8'd0;
                    misses_next = 8'd0;
                end
            end
            AUTO_ODE, AUTO_DRM: begin
                if (fall[own_idx]) begin
                    mode_next = FREE;
                end else if (bc_q == BC_LAST) begin
                    bc_next = '0;
                    if (at_last) begin
                        mode_next = FREE;
                        done_next = 1'b1;
                    end else begin
                        step_next = step_q + 5'd1;
                    end
                end else begin
                    bc_next = bc_q + 1'b1;
                end
            end
            GUIDE_ODE, GUIDE_DRM: begin
                if (fall[own_idx]) begin
                    mode_next = FREE;
                end else if (press_q) begin
                    if (press_code_q == cur_note) begin
                        hits_next = sat_inc(hits_q);
                        if (at_last) begin
                            mode_next = FREE;
                            done_next = 1'b1;
                        end else begin
                            step_next = step_q + 5'd1;
                        end
                    end else begin
                        misses_next = sat_inc(misses_q);
                    end
                end
            end
            default: mode_next = FREE;
        endcase

        // The audible note is registered from the state before the edge, so
        // an auto song starts silent on ROM[0] and sounds one edge later.
        note_next  = decode_sw(sw_sync);
        valid_next = (sw_sync != 8'd0);
        if (entering && is_auto(mode_next)) begin
            note_next  = song_note(mode_next, 5'd0);
            valid_next = 1'b0;
        end else if (is_auto(mode_q)) begin
            note_next  = cur_note;
            valid_next = (bc_q < BC_ON);
        end

        expect_next = 8'd0;
        if (is_guide(mode_next)) begin
            expect_next = note_onehot(song_note(mode_next, step_next));
        end
    end

    // Input synchronisers, debounce counters and press detection.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_meta     <= '0;
            req_sync     <= '0;
            sw_meta      <= '0;
            sw_sync      <= '0;
            sw_prev      <= '0;
            press_q      <= 1'b0;
            press_code_q <= '0;
            deb_q        <= '0;
            cnt_q        <= '0;
        end else begin
            req_meta     <= {bus.ODETOJOY_AUTO, bus.DOREMI_AUTO, bus.ODETOJOY, bus.DOREMI};
            req_sync     <= req_meta;
            sw_meta      <= bus.sw;
            sw_sync      <= sw_meta;
            sw_prev      <= sw_sync;
            press_q      <= (sw_prev == 8'd0) && (sw_sync != 8'd0);
            press_code_q <= decode_sw(sw_sync);
            deb_q        <= deb_next;
            cnt_q        <= cnt_next;
        end
    end

    // Mode state, song position, scores and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q   <= FREE;
            step_q   <= '0;
            bc_q     <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            expect_q <= '0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_next;
            step_q   <= step_next;
            bc_q     <= bc_next;
            hits_q   <= hits_next;
            misses_q <= misses_next;
            note_q   <= note_next;
            valid_q  <= valid_next;
            expect_q <= expect_next;
            done_q   <= done_next;
        end
    end

    assign bus.note_code  = note_q;
    assign bus.note_valid = valid_q;
    assign bus.mode       = mode_q;
    assign bus.expect_led = expect_q;
    assign bus.step       = step_q;
    assign bus.hits       = hits_q;
    assign bus.misses     = misses_q;
    assign bus.song_done  = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer
// Self-checking bench for song_sequencer with BEAT_DIV=10, GAP=2, DEBOUNCE=4.
// Manual decode is table driven; expected note outputs go through a
// scoreboard queue; mode, guided scoring and reset are hand sequences.
// -----------------------------------------------------------------------------
module tb_song_sequencer;

    localparam int BEAT_DIV = 10;
    localparam int GAP      = 2;
    localparam int DEBOUNCE = 4;

    logic clk = 1'b0;
    logic rst_n;

    song_sequencer_if bus();

    song_sequencer #(
        .BEAT_DIV (BEAT_DIV),
        .GAP      (GAP),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sw;
        logic [3:0] note;
        logic       valid;
    } vec_t;

    typedef struct packed {
        logic [3:0] note;
        logic       valid;
    } exp_t;

    typedef struct packed {
        logic [7:0] sw;
        logic [7:0] hits;
        logic [7:0] misses;
        logic [4:0] step;
    } press_t;

    int   vectors_applied = 0;
    int   miscompares     = 0;
    int   done_count      = 0;
    exp_t sb[$];

    int ode_rom[30] = '{3,3,4,5,5,4,3,2,1,1,2,3,3,2,2,3,3,4,5,5,4,3,2,1,1,2,3,2,1,1};
    int drm_rom[16] = '{1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1};

    always @(negedge clk) begin
        if (bus.song_done === 1'b1) done_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int model_decode(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) begin
            if (s[i]) return 8 - i;
        end
        return 0;
    endfunction

    function automatic logic [7:0] model_led(input int note);
        logic [7:0] r;
        r = 8'd0;
        r[8 - note] = 1'b1;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors_applied++;
        if (act !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        bus.sw  = v.sw;
        e.note  = v.note;
        e.valid = v.valid;
        sb.push_back(e);
    endtask

    task automatic popAndCheck(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_note"}, 32'(bus.note_code), 32'(e.note));
            checkOutput({name, "_valid"}, 32'(bus.note_valid), 32'(e.valid));
        end
    endtask

    initial begin
        vec_t   vecs[7];
        press_t presses[3];
        int     d0;
        int     waited;
        logic [7:0] sw_v;
        logic [7:0] prev_hits;

        vecs[0] = '{sw: 8'b0010_1000, note: 4'd3, valid: 1'b1};
        vecs[1] = '{sw: 8'b0000_0000, note: 4'd0, valid: 1'b0};
        vecs[2] = '{sw: 8'b1000_0000, note: 4'd1, valid: 1'b1};
        vecs[3] = '{sw: 8'b0000_0001, note: 4'd8, valid: 1'b1};
        vecs[4] = '{sw: 8'b1111_1111, note: 4'd1, valid: 1'b1};
        vecs[5] = '{sw: 8'b0000_0110, note: 4'd6, valid: 1'b1};
        vecs[6] = '{sw: 8'b0100_0000, note: 4'd2, valid: 1'b1};

        presses[0] = '{sw: 8'b0010_0000, hits: 8'd1, misses: 8'd0, step: 5'd1};
        presses[1] = '{sw: 8'b0001_0000, hits: 8'd1, misses: 8'd1, step: 5'd1};
        presses[2] = '{sw: 8'b0010_0000, hits: 8'd2, misses: 8'd1, step: 5'd2};

        rst_n             = 1'b0;
        bus.ODETOJOY_AUTO = 1'b0;
        bus.DOREMI_AUTO   = 1'b0;
        bus.ODETOJOY      = 1'b0;
        bus.DOREMI        = 1'b0;
        bus.sw            = 8'd0;
        tick(3);
        checkOutput("reset_mode", 32'(bus.mode), 0);
        checkOutput("reset_note", 32'(bus.note_code), 0);
        checkOutput("reset_valid", 32'(bus.note_valid), 0);
        checkOutput("reset_step", 32'(bus.step), 0);
        checkOutput("reset_hits", 32'(bus.hits), 0);
        checkOutput("reset_led", 32'(bus.expect_led), 0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] manual decode table");
        applyStimulus(vecs[0]);
        tick(2);
        checkOutput("manual_latency_note", 32'(bus.note_code), 0);
        tick(1);
        popAndCheck("manual_0");
        for (int i = 1; i < 7; i++) begin
            applyStimulus(vecs[i]);
            tick(3);
            popAndCheck("manual");
            checkOutput("manual_mode", 32'(bus.mode), 0);
            checkOutput("manual_led", 32'(bus.expect_led), 0);
        end
        bus.sw = 8'd0;
        tick(4);

        $display("[TB] bouncing ODETOJOY_AUTO then auto play");
        bus.ODETOJOY_AUTO = 1'b1; tick(1);
        bus.ODETOJOY_AUTO = 1'b0; tick(1);
        bus.ODETOJOY_AUTO = 1'b1; tick(1);
        bus.ODETOJOY_AUTO = 1'b0; tick(1);
        bus.ODETOJOY_AUTO = 1'b1;
        tick(5);
        checkOutput("bounce_mode_early", 32'(bus.mode), 0);
        d0 = done_count;
        for (int t = 0; t <= 300; t++) begin
            exp_t e;
            if (t == 0) begin
                e.note  = 4'(ode_rom[0]);
                e.valid = 1'b0;
            end else begin
                e.note  = 4'(ode_rom[(t - 1) / BEAT_DIV]);
                e.valid = (((t - 1) % BEAT_DIV) < (BEAT_DIV - GAP));
            end
            sb.push_back(e);
        end
        for (int t = 0; t <= 300; t++) begin
            tick(1);
            popAndCheck("auto_ode");
            if (t == 0) begin
                checkOutput("auto_entry_mode", 32'(bus.mode), 1);
                checkOutput("auto_led", 32'(bus.expect_led), 0);
            end
            if ((t % BEAT_DIV) == 0 && t < 300) checkOutput("auto_step", 32'(bus.step), 32'(t / BEAT_DIV));
            if (t == 299) begin
                checkOutput("auto_mode_before_end", 32'(bus.mode), 1);
                checkOutput("auto_done_early", 32'(bus.song_done), 0);
            end
            if (t == 300) begin
                checkOutput("auto_end_mode", 32'(bus.mode), 0);
                checkOutput("auto_done_pulse", 32'(bus.song_done), 1);
            end
        end
        tick(1);
        checkOutput("auto_done_width", 32'(bus.song_done), 0);
        checkOutput("auto_done_count", 32'(done_count - d0), 1);
        bus.ODETOJOY_AUTO = 1'b0;
        tick(8);

        $display("[TB] simultaneous requests and mode lock");
        d0 = done_count;
        bus.DOREMI      = 1'b1;
        bus.DOREMI_AUTO = 1'b1;
        tick(6);
        checkOutput("simul_mode", 32'(bus.mode), 2);
        bus.ODETOJOY_AUTO = 1'b1;
        tick(10);
        checkOutput("lock_mode", 32'(bus.mode), 2);
        bus.DOREMI_AUTO = 1'b0;
        tick(5);
        checkOutput("drop_mode_early", 32'(bus.mode), 2);
        tick(1);
        checkOutput("drop_mode", 32'(bus.mode), 0);
        tick(2);
        checkOutput("drop_no_done", 32'(done_count - d0), 0);
        bus.DOREMI        = 1'b0;
        bus.ODETOJOY_AUTO = 1'b0;
        tick(8);
        checkOutput("drop_stays_free", 32'(bus.mode), 0);

        $display("[TB] guided ODE with a miss");
        bus.ODETOJOY = 1'b1;
        tick(6);
        checkOutput("guide_mode", 32'(bus.mode), 3);
        checkOutput("guide_led0", 32'(bus.expect_led), 32'(model_led(ode_rom[0])));
        prev_hits = 8'd0;
        for (int i = 0; i < 3; i++) begin
            bus.sw = presses[i].sw;
            tick(3);
            checkOutput("guide_hits_latency", 32'(bus.hits), 32'(prev_hits));
            tick(1);
            checkOutput("guide_hits", 32'(bus.hits), 32'(presses[i].hits));
            checkOutput("guide_misses", 32'(bus.misses), 32'(presses[i].misses));
            checkOutput("guide_step", 32'(bus.step), 32'(presses[i].step));
            checkOutput("guide_note", 32'(bus.note_code), 32'(model_decode(presses[i].sw)));
            prev_hits = presses[i].hits;
            bus.sw = 8'd0;
            tick(4);
        end
        checkOutput("guide_led2", 32'(bus.expect_led), 32'(model_led(ode_rom[2])));
        bus.ODETOJOY = 1'b0;
        tick(6);
        checkOutput("guide_exit_mode", 32'(bus.mode), 0);
        checkOutput("guide_exit_led", 32'(bus.expect_led), 0);
        tick(4);
        checkOutput("guide_hold_hits", 32'(bus.hits), 2);
        checkOutput("guide_hold_misses", 32'(bus.misses), 1);
        checkOutput("guide_hold_step", 32'(bus.step), 2);

        $display("[TB] guided DRM completion");
        d0 = done_count;
        bus.DOREMI = 1'b1;
        tick(6);
        checkOutput("drm_mode", 32'(bus.mode), 4);
        checkOutput("drm_hits_clear", 32'(bus.hits), 0);
        checkOutput("drm_misses_clear", 32'(bus.misses), 0);
        for (int i = 0; i < 16; i++) begin
            sw_v   = 8'd1 << (8 - drm_rom[i]);
            bus.sw = sw_v;
            tick(4);
            checkOutput("drm_hits", 32'(bus.hits), 32'(i + 1));
            if (i < 15) begin
                checkOutput("drm_step", 32'(bus.step), 32'(i + 1));
                checkOutput("drm_led", 32'(bus.expect_led), 32'(model_led(drm_rom[i + 1])));
            end else begin
                checkOutput("drm_end_mode", 32'(bus.mode), 0);
                checkOutput("drm_done_pulse", 32'(bus.song_done), 1);
            end
            bus.sw = 8'd0;
            tick(4);
        end
        checkOutput("drm_done_count", 32'(done_count - d0), 1);
        checkOutput("drm_misses", 32'(bus.misses), 0);
        tick(20);
        checkOutput("drm_hold_hits", 32'(bus.hits), 16);
        checkOutput("drm_hold_mode", 32'(bus.mode), 0);
        bus.DOREMI = 1'b0;
        tick(8);

        $display("[TB] reset in the middle of AUTO_DRM");
        bus.DOREMI_AUTO = 1'b1;
        tick(6);
        checkOutput("rst_entry_mode", 32'(bus.mode), 2);
        waited = 0;
        while (bus.step !== 5'd7 && waited < 200) begin
            tick(1);
            waited++;
        end
        checkOutput("rst_reach_step7", 32'(bus.step), 7);
        tick(3);
        d0 = done_count;
        rst_n = 1'b0;
        #2;
        checkOutput("rst_mode", 32'(bus.mode), 0);
        checkOutput("rst_note", 32'(bus.note_code), 0);
        checkOutput("rst_valid", 32'(bus.note_valid), 0);
        checkOutput("rst_step", 32'(bus.step), 0);
        checkOutput("rst_hits", 32'(bus.hits), 0);
        checkOutput("rst_misses", 32'(bus.misses), 0);
        checkOutput("rst_led", 32'(bus.expect_led), 0);
        checkOutput("rst_done", 32'(bus.song_done), 0);
        bus.DOREMI_AUTO = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(20);
        checkOutput("rst_after_mode", 32'(bus.mode), 0);
        checkOutput("rst_no_done", 32'(done_count - d0), 0);
        bus.DOREMI_AUTO = 1'b1;
        tick(5);
        checkOutput("rst_reentry_early", 32'(bus.mode), 0);
        tick(1);
        checkOutput("rst_reentry_mode", 32'(bus.mode), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
